// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV M-extension multiply/divide unit with radix-2 restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative shift-add multiplier with a single-cycle one.
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            valid_in,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(XLEN);
    localparam logic [CW-1:0]   CNT_WORD = CW'(32'd32);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(32'd1);
    localparam logic [XLEN-1:0] ONE_X    = XLEN'(32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v[31:0];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v[31:0];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
        return ~v + ONE_X;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;
    logic            word_q, word_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            word_s, is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic            b_zero_s, ovf_s, wbad_s, short_s;
    logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, min_neg_s, short_val_s;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fa_s, fb_s, fprod_s;
    logic [XLEN-1:0]   fast_val_s;

    // Single-cycle product; operands extended to 2*XLEN so the low 2*XLEN bits are exact.
    always_comb begin
        fa_s    = {{XLEN{a_sgn_s & a_ext_s[XLEN-1]}}, a_ext_s};
        fb_s    = {{XLEN{b_sgn_s & b_ext_s[XLEN-1]}}, b_ext_s};
        fprod_s = fa_s * fb_s;
        if (op == 3'd0) begin
            fast_val_s = word_s ? sext32(fprod_s[XLEN-1:0]) : fprod_s[XLEN-1:0];
        end else begin
            fast_val_s = fprod_s[2*XLEN-1:XLEN];
        end
    end
`endif

    // Operand decode, magnitudes and the one-cycle short-path result.
    always_comb begin
        word_s   = word & (XLEN == 64);
        is_div_s = op[2];
        // MUL keeps the low half only, which is sign-agnostic, so it runs unsigned.
        a_sgn_s  = is_div_s ? ~op[0] : ((op == 3'd1) | (op == 3'd2));
        b_sgn_s  = is_div_s ? ~op[0] : (op == 3'd1);
        if (word_s) begin
            a_ext_s = a_sgn_s ? sext32(src1) : zext32(src1);
            b_ext_s = b_sgn_s ? sext32(src2) : zext32(src2);
        end else begin
            a_ext_s = src1;
            b_ext_s = src2;
        end
        a_neg_s   = a_sgn_s & a_ext_s[XLEN-1];
        b_neg_s   = b_sgn_s & b_ext_s[XLEN-1];
        a_mag_s   = a_neg_s ? neg2(a_ext_s) : a_ext_s;
        b_mag_s   = b_neg_s ? neg2(b_ext_s) : b_ext_s;
        min_neg_s = word_s ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        b_zero_s  = (b_ext_s == '0);
        ovf_s     = is_div_s & ~op[0] & (a_ext_s == min_neg_s) & (b_ext_s == '1);
        wbad_s    = word_s & ~is_div_s & (op != 3'd0);
        if (wbad_s) begin
            short_s     = 1'b1;
            short_val_s = '0;
        end else if (is_div_s & b_zero_s) begin
            short_s     = 1'b1;
            short_val_s = op[1] ? (word_s ? sext32(src1) : src1) : '1;
        end else if (ovf_s) begin
            short_s     = 1'b1;
            short_val_s = op[1] ? '0 : min_neg_s;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            short_s     = ~is_div_s;
            short_val_s = fast_val_s;
`else
            short_s     = 1'b0;
            short_val_s = '0;
`endif
        end
    end

    logic [XLEN:0]   rs_s, diff_s, sum_s;
    logic [XLEN-1:0] acc_n_s, sh_n_s, raw_s, fin_s;

    // One iteration of restoring divide or shift-add multiply, plus the signed fix-up of the result.
    always_comb begin
        rs_s   = {acc_q, sh_q[XLEN-1]};
        diff_s = rs_s - {1'b0, opd_q};
        sum_s  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
        if (op_q[2]) begin
            if (!diff_s[XLEN]) begin
                acc_n_s = diff_s[XLEN-1:0];
                sh_n_s  = {sh_q[XLEN-2:0], 1'b1};
            end else begin
                acc_n_s = rs_s[XLEN-1:0];
                sh_n_s  = {sh_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_n_s = sum_s[XLEN:1];
            sh_n_s  = {sum_s[0], sh_q[XLEN-1:1]};
        end
        raw_s = op_q[1] ? acc_n_s : sh_n_s;
        if (op_q[2]) begin
            raw_s = neg_q ? neg2(raw_s) : raw_s;
            fin_s = word_q ? sext32(raw_s) : raw_s;
        end else if (op_q == 3'd0) begin
            // After 32 steps the low product word sits in the top half of sh.
            fin_s = word_q ? sext32(sh_n_s >> 6'd32) : sh_n_s;
        end else begin
            // High half of the negated 2*XLEN product: borrow propagates only when the low half is zero.
            fin_s = neg_q ? (~acc_n_s + ((sh_n_s == '0) ? ONE_X : '0)) : acc_n_s;
        end
    end

    // Next-state and datapath register update; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opd_d    = opd_q;
        neg_d    = neg_q;
        op_d     = op_q;
        word_d   = word_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in && short_s) begin
                    state_d  = S_DONE;
                    result_d = short_val_s;
                    rd_out_d = rd_in;
                end else if (valid_in) begin
                    state_d = S_CALC;
                    cnt_d   = word_s ? CNT_WORD : CNT_FULL;
                    acc_d   = '0;
                    op_d    = op;
                    word_d  = word_s;
                    rd_d    = rd_in;
                    if (is_div_s) begin
                        sh_d  = word_s ? (a_mag_s << 6'd32) : a_mag_s;
                        opd_d = b_mag_s;
                        neg_d = op[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                    end else begin
                        sh_d  = b_mag_s;
                        opd_d = a_mag_s;
                        neg_d = a_neg_s ^ b_neg_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = acc_n_s;
                sh_d  = sh_n_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = fin_s;
                    rd_out_d = rd_q;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d  = S_IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opd_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= 3'd0;
            word_q   <= 1'b0;
            rd_q     <= 5'd0;
            result_q <= '0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opd_q    <= opd_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            word_q   <= word_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign stall_req = ((state_q == S_IDLE) & valid_in & ~clear) | (state_q == S_CALC);
    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=64): directed spec vectors, random ops against a reference model.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 65;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, valid_in, word;
    logic [2:0]  op;
    logic [4:0]  rd_in, rd_out;
    logic [63:0] src1, src2, result;
    logic        stall_req, busy, done;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e;
        int          lat;
    } vec_t;

    ex_muldiv #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .op(op), .word(word),
        .rd_in(rd_in), .src1(src1), .src2(src2), .stall_req(stall_req), .busy(busy),
        .done(done), .result(result), .rd_out(rd_out)
    );

    initial forever #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, pr;
        longint       sa, sb;
        int           sa32, sb32, r32;
        logic [31:0]  ua32, ub32;
        logic [63:0]  r;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        r = 64'd0; r32 = 0;
        if (w) begin
            if (f == 3'd0) r32 = sa32 * sb32;
            else if (f == 3'd1 || f == 3'd2 || f == 3'd3) r32 = 0;
            else if (f[0]) begin
                if (ub32 == 32'd0) r32 = f[1] ? sa32 : -32'sd1;
                else r32 = f[1] ? int'(ua32 % ub32) : int'(ua32 / ub32);
            end else begin
                if (sb32 == 0) r32 = f[1] ? sa32 : -32'sd1;
                else if (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) r32 = f[1] ? 0 : sa32;
                else r32 = f[1] ? (sa32 % sb32) : (sa32 / sb32);
            end
            r = {{32{r32[31]}}, r32};
        end else begin
            if (!f[2]) begin
                pa = (f == 3'd1 || f == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
                pb = (f == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
                pr = pa * pb;
                r  = (f == 3'd0) ? pr[63:0] : pr[127:64];
            end else if (f[0]) begin
                if (b == 64'd0) r = f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
                else r = f[1] ? (a % b) : (a / b);
            end else begin
                if (sb == 64'sd0) r = f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
                else if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) r = f[1] ? 64'd0 : a;
                else r = f[1] ? 64'(sa % sb) : 64'(sa / sb);
            end
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic bz, ov;
        bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ov = (f == 3'd4 || f == 3'd6) &&
             (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (w && (f == 3'd1 || f == 3'd2 || f == 3'd3)) return 1;
        if (f[2]) return (bz || ov) ? 1 : (w ? 33 : 65);
        return (ML == 1) ? 1 : (w ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 20));
            2: return -64'($urandom_range(1, 20));
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, 32'h8000_0000};
        endcase
    endfunction

    // Issues one op, holds it until done, and reports what was observed.
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          output logic [63:0] res, output logic [4:0] rdo, output int lat,
                          output int sc, output logic sd);
        @(negedge clk);
        op = f; word = w; src1 = a; src2 = b; rd_in = rd; valid_in = 1'b1;
        #1;
        sc  = stall_req ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (stall_req) sc++;
        end
        res = result; rdo = rd_out; sd = stall_req;
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++;
        if ({done, busy, stall_req, rd_out} !== 8'd0)
            begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {done, busy, stall_req, rd_out}); end
        valid_in = 1'b1; #1;
        checks++;
        if (stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall_follows got=%b exp=1", stall_req); end
        valid_in = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v[11];
        logic [63:0] res; logic [4:0] rdo; int lat, sc; logic sd;
        v[0]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        v[1]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        v[2]  = '{3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        v[3]  = '{3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 1};
        v[4]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        v[5]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        v[6]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, ML};
        v[7]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, ML};
        v[8]  = '{3'd0, 1'b0, 64'd3, 64'd5, 64'd15, ML};
        v[9]  = '{3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        v[10] = '{3'd5, 1'b1, 64'd100, 64'd7, 64'd14, 33};
        for (int i = 0; i < 11; i++) begin
            run_op(v[i].f, v[i].w, v[i].a, v[i].b, 5'(i + 1), res, rdo, lat, sc, sd);
            checks++;
            if (res !== v[i].e) begin errors++; $display("FAIL dir_result[%0d] got=%h exp=%h", i, res, v[i].e); end
            checks++;
            if (rdo !== 5'(i + 1)) begin errors++; $display("FAIL dir_rd[%0d] got=%0d exp=%0d", i, rdo, i + 1); end
            checks++;
            if (lat !== v[i].lat) begin errors++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, v[i].lat); end
            checks++;
            if (sc !== v[i].lat || sd !== 1'b0)
                begin errors++; $display("FAIL dir_stall[%0d] got=%0d/%b exp=%0d/0", i, sc, sd, v[i].lat); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, e; logic [2:0] f; logic w; logic [4:0] rd, rdo; int lat, sc, el; logic sd;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1));
            a = pick(); b = pick(); rd = 5'($urandom_range(0, 31));
            e = model(f, w, a, b); el = exp_lat(f, w, a, b);
            run_op(f, w, a, b, rd, res, rdo, lat, sc, sd);
            checks++;
            if (res !== e || rdo !== rd)
                begin errors++; $display("FAIL rnd_result op=%0d w=%b a=%h b=%h got=%h/%0d exp=%h/%0d", f, w, a, b, res, rdo, e, rd); end
            checks++;
            if (lat !== el || sc !== el || sd !== 1'b0)
                begin errors++; $display("FAIL rnd_timing op=%0d w=%b got=%0d/%0d exp=%0d", f, w, lat, sc, el); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        op = 3'd5; word = 1'b0; src1 = 64'h1234; src2 = 64'd0; rd_in = 5'd3; valid_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFFF)
            begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/ffffffffffffffff", done, result); end
        src1 = 64'd100; src2 = 64'd7; rd_in = 5'd4;
        @(posedge clk); #1;
        checks++;
        if ({done, busy, stall_req} !== 3'b001)
            begin errors++; $display("FAIL b2b_accept got=%b exp=001", {done, busy, stall_req}); end
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        valid_in = 1'b0;
        checks++;
        if (lat !== 65 || result !== 64'd14 || rd_out !== 5'd4)
            begin errors++; $display("FAIL b2b_second got=%0d/%h/%0d exp=65/14/4", lat, result, rd_out); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse got=%b exp=0", done); end
    endtask

    task automatic test_clear();
        logic [63:0] prev, res; logic [4:0] prev_rd, rdo; int lat, sc; logic sd;
        prev = result; prev_rd = rd_out;
        @(negedge clk);
        op = 3'd5; word = 1'b0; src1 = 64'hFFFF_0000_1234_5678; src2 = 64'd3; rd_in = 5'd11; valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got=%b exp=1", busy); end
        clear = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if ({done, busy, stall_req} !== 3'b000 || result !== prev || rd_out !== prev_rd)
            begin errors++; $display("FAIL clear_abort got=%b/%h/%0d exp=000/%h/%0d", {done, busy, stall_req}, result, rd_out, prev, prev_rd); end
        run_op(3'd5, 1'b0, 64'd9, 64'd3, 5'd12, res, rdo, lat, sc, sd);
        checks++;
        if (res !== 64'd3 || rdo !== 5'd12 || lat !== 65)
            begin errors++; $display("FAIL clear_next got=%h/%0d/%0d exp=3/12/65", res, rdo, lat); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; logic [4:0] rdo; int lat, sc; logic sd;
        @(negedge clk);
        op = 3'd4; word = 1'b0; src1 = 64'd1000; src2 = 64'd3; rd_in = 5'd13; valid_in = 1'b1;
        repeat (5) @(posedge clk);
        #3; rst = 1'b1; valid_in = 1'b0;
        #1;
        checks++;
        if ({done, busy, stall_req} !== 3'b000 || result !== 64'd0 || rd_out !== 5'd0)
            begin errors++; $display("FAIL rst_mid got=%b/%h/%0d exp=000/0/0", {done, busy, stall_req}, result, rd_out); end
        @(negedge clk); rst = 1'b0;
        run_op(3'd0, 1'b0, 64'd2, 64'd2, 5'd14, res, rdo, lat, sc, sd);
        checks++;
        if (res !== 64'd4 || rdo !== 5'd14 || lat !== ML)
            begin errors++; $display("FAIL rst_then_mul got=%h/%0d/%0d exp=4/14/%0d", res, rdo, lat, ML); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; valid_in = 1'b0; word = 1'b0; op = 3'd0;
        rd_in = 5'd0; src1 = 64'd0; src2 = 64'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
